mem_write_checker: RTL and testbench
====================================

Name: mem_write_checker

Overview:
- Synthesizable, parametrised monitor for the mips_mem memory write interface (memwrite/adr/writedata).
- Compares every write against a loadable table of up to DEPTH expected (address, data) pairs, in order.
- Enforces a cycle-count timeout and reports done/pass/fail, error count and first-mismatch capture.
- Successor to the single-write Fibonacci end check; usable in benches and on FPGA builds where $display is unavailable.

Parameters:
- WIDTH, 8, address and data width of the monitored bus.
- DEPTH, 4, number of expected-write table entries.
- TIMEOUT, 1000, cycles allowed from start to completion.
- CNTW, 16, width of the cycle and error counters.
- STOP_ON_ERR, 1, 1 = fail on first mismatch; 0 = check all entries and fail at the end if any mismatched.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- memwrite  in  1  monitored write strobe; each high cycle is one write.
- adr  in  WIDTH  monitored write address.
- writedata  in  WIDTH  monitored write data.
- exp_we  in  1  table write enable; honoured only in IDLE/PASS/FAIL.
- exp_idx  in  $clog2(DEPTH)  table entry index.
- exp_adr  in  WIDTH  expected address for the entry.
- exp_data  in  WIDTH  expected data for the entry.
- exp_len  in  $clog2(DEPTH+1)  entries to check; sampled on start and clamped to DEPTH.
- start  in  1  single-cycle pulse that begins a check.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS.
- fail  out  1  high in FAIL.
- timeout  out  1  FAIL was caused by timeout.
- match_cnt  out  $clog2(DEPTH+1)  writes checked so far.
- err_cnt  out  CNTW  mismatching writes; saturates.
- cycles  out  CNTW  cycles since start; saturates.
- fail_adr  out  WIDTH  address of the first mismatching write.
- fail_data  out  WIDTH  data of the first mismatching write.

Behaviour:
- Reset: state IDLE. All outputs 0. Table entries 0. len register 0.
- States: IDLE, RUN, PASS, FAIL.
- start in any state: clear counters and status, latch len = min(exp_len, DEPTH), go to RUN.
  - If len = 0, go to PASS instead of RUN.
  - memwrite in the start cycle is ignored.
- Table load: exp_we in any state except RUN writes entry exp_idx (indices >= DEPTH are ignored). exp_we during RUN is ignored.
- RUN, each cycle:
  - cycles increments.
  - If memwrite is high, compare (adr, writedata) with entry[match_cnt].
  - On a mismatch: err_cnt increments; on the first mismatch only, capture fail_adr/fail_data.
  - match_cnt increments on every write, match or mismatch.
- STOP_ON_ERR=1: a mismatch moves to FAIL on the next edge.
- STOP_ON_ERR=0: when match_cnt reaches len, go to PASS if err_cnt = 0, otherwise FAIL.
- STOP_ON_ERR=1 completion: when match_cnt reaches len with no mismatch, go to PASS.
- Latency: status is visible the cycle after the last write edge.
- Timeout: if cycles reaches TIMEOUT-1 while still in RUN, go to FAIL with timeout=1.
  - A write in that same cycle is evaluated first; if it completes the sequence, PASS wins and timeout stays 0.
- PASS/FAIL hold until start or reset. Further writes are ignored and no counter changes.
- Reset asserted mid-RUN returns to IDLE immediately and clears the table.
- Arithmetic:
  - Comparisons are full-width equality.
  - Counters saturate at all-ones.
  - match_cnt never exceeds len.

Decomposition:
- Shared package holds the state encoding constants (IDLE=0, RUN=1, PASS=2, FAIL=3) and the index/length width function.
- Sub-module exp_table (DEPTH x 2*WIDTH register file: one synchronous write port, one combinational read port) is natural.
- FSM and counters stay in mem_write_checker.

Test Plan:
- Load entry0=(FF,0D), exp_len=1, start; write FF/0D 10 cycles later -> pass=1, match_cnt=1, err_cnt=0 on the next cycle.
- Same table; write FF/0C -> fail=1, fail_adr=FF, fail_data=0C, err_cnt=1, timeout=0.
- STOP_ON_ERR=0, table (10,01),(11,01),(12,02),(13,03); writes 10/01, 11/05, 12/02, 13/03 -> fail after the 4th write, err_cnt=1, fail_adr=11, fail_data=05.
- TIMEOUT=50, exp_len=1, no writes -> fail=1, timeout=1, cycles=49; a write at cycle 49 matching entry0 -> pass=1 instead.
- exp_len=0, start -> pass=1 the next cycle; exp_len=7 with DEPTH=4 -> len clamped to 4.
- Reset pulse during RUN after 2 writes -> all outputs 0, state IDLE; re-load and start -> normal pass.

Source files
------------

// File: rtl/mem_write_checker_pkg.sv
// mem_write_checker_pkg: state encoding and index/length width helper for the write checker.
package mem_write_checker_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PASS = 2'd2, FAIL = 2'd3} state_t;
    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mem_write_checker_if.sv
// mem_write_checker_if: monitored write bus plus expected-table load and start controls.
interface mem_write_checker_if #(parameter int WIDTH = 8, parameter int DEPTH = 4);
    localparam int IW = mem_write_checker_pkg::cw(DEPTH);
    localparam int LW = mem_write_checker_pkg::cw(DEPTH + 1);
    logic             memwrite;
    logic [WIDTH-1:0] adr;
    logic [WIDTH-1:0] writedata;
    logic             exp_we;
    logic [IW-1:0]    exp_idx;
    logic [WIDTH-1:0] exp_adr;
    logic [WIDTH-1:0] exp_data;
    logic [LW-1:0]    exp_len;
    logic             start;
    modport master (output memwrite, adr, writedata, exp_we, exp_idx, exp_adr, exp_data, exp_len, start);
    modport slave  (input  memwrite, adr, writedata, exp_we, exp_idx, exp_adr, exp_data, exp_len, start);
endinterface

// File: rtl/mem_write_checker_exp_table.sv
// mem_write_checker_exp_table: expected (address, data) register file, sync write, comb read.
module mem_write_checker_exp_table #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int IW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IW-1:0]    idx,
    input  logic [WIDTH-1:0] wadr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IW-1:0]    ridx,
    output logic [WIDTH-1:0] radr,
    output logic [WIDTH-1:0] rdata
);
    logic [2*WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk or posedge reset)
        if (reset)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (we && int'(idx) < DEPTH)
            mem[idx] <= {wadr, wdata};
    assign {radr, rdata} = (int'(ridx) < DEPTH) ? mem[ridx] : '0;
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: checks each bus write against the expected table in order, with timeout,
// error counting and first-mismatch capture.
module mem_write_checker import mem_write_checker_pkg::*; #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT     = 1000,
    parameter int CNTW        = 16,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    mem_write_checker_if.slave        bus,
    output logic                      done,
    output logic                      pass,
    output logic                      fail,
    output logic                      timeout,
    output logic [cw(DEPTH+1)-1:0]    match_cnt,
    output logic [CNTW-1:0]           err_cnt,
    output logic [CNTW-1:0]           cycles,
    output logic [WIDTH-1:0]          fail_adr,
    output logic [WIDTH-1:0]          fail_data
);
    localparam int IW = cw(DEPTH);
    localparam int LW = cw(DEPTH + 1);
    localparam logic [CNTW-1:0] CMAX = '1;
    localparam logic [CNTW-1:0] TLIM = CNTW'(TIMEOUT - 1);

    state_t           state, state_n;
    logic [LW-1:0]    len, len_n, match_n, req_len;
    logic [CNTW-1:0]  err_n, cyc_n;
    logic [WIDTH-1:0] fa_n, fd_n, ref_adr, ref_data;
    logic             to_n, hit, mm, last;

    mem_write_checker_exp_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IW(IW)) u_tab (
        .clk(clk), .reset(reset),
        .we(bus.exp_we && state != RUN), .idx(bus.exp_idx),
        .wadr(bus.exp_adr), .wdata(bus.exp_data),
        .ridx(IW'(match_cnt)), .radr(ref_adr), .rdata(ref_data)
    );

    assign req_len = (bus.exp_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.exp_len;
    assign done    = (state == PASS) || (state == FAIL);
    assign pass    = state == PASS;
    assign fail    = state == FAIL;

    always_comb begin
        state_n = state;
        len_n   = len;
        match_n = match_cnt;
        err_n   = err_cnt;
        cyc_n   = cycles;
        fa_n    = fail_adr;
        fd_n    = fail_data;
        to_n    = timeout;
        hit     = state == RUN && bus.memwrite;
        mm      = hit && (bus.adr != ref_adr || bus.writedata != ref_data);
        last    = hit && (match_cnt + LW'(1) == len);
        if (bus.start) begin
            len_n   = req_len;
            match_n = '0;
            err_n   = '0;
            cyc_n   = '0;
            fa_n    = '0;
            fd_n    = '0;
            to_n    = 1'b0;
            state_n = (req_len == '0) ? PASS : RUN;
        end else if (state == RUN) begin
            // cycles stops at the timeout limit so it reads TIMEOUT-1 after a timeout
            cyc_n   = (cycles == TLIM || cycles == CMAX) ? cycles : cycles + CNTW'(1);
            match_n = hit ? match_cnt + LW'(1) : match_cnt;
            err_n   = (mm && err_cnt != CMAX) ? err_cnt + CNTW'(1) : err_cnt;
            fa_n    = (mm && err_cnt == '0) ? bus.adr : fail_adr;
            fd_n    = (mm && err_cnt == '0) ? bus.writedata : fail_data;
            if (mm && STOP_ON_ERR)
                state_n = FAIL;
            else if (last)
                state_n = (err_n == '0) ? PASS : FAIL;
            else if (cycles == TLIM) begin
                state_n = FAIL;
                to_n    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            match_cnt <= '0;
            err_cnt   <= '0;
            cycles    <= '0;
            fail_adr  <= '0;
            fail_data <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            match_cnt <= match_n;
            err_cnt   <= err_n;
            cycles    <= cyc_n;
            fail_adr  <= fa_n;
            fail_data <= fd_n;
            timeout   <= to_n;
        end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed and random runs on a stop-on-error and a check-all instance,
// compared against a list-based outcome model.
module tb_mem_write_checker;
    localparam int TMO = 50;

    typedef struct { int k; logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic p; logic f; logic to; int mc; int ec; int cy; logic [7:0] fa; logic [7:0] fd; } res_t;

    logic clk = 1'b0, reset = 1'b1;
    int n_chk = 0, n_err = 0, kk = 0, wp = 0;
    wr_t wq[$];
    logic [7:0] tab_a[4], tab_d[4];

    logic s_done, s_pass, s_fail, s_to, c_done, c_pass, c_fail, c_to;
    logic [2:0] s_mc, c_mc;
    logic [15:0] s_ec, s_cy, c_ec, c_cy;
    logic [7:0] s_fa, s_fd, c_fa, c_fd;

    mem_write_checker_if #(.WIDTH(8), .DEPTH(4)) bus ();

    mem_write_checker #(.WIDTH(8), .DEPTH(4), .TIMEOUT(TMO), .CNTW(16), .STOP_ON_ERR(1'b1)) dut_s (
        .clk(clk), .reset(reset), .bus(bus), .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_to),
        .match_cnt(s_mc), .err_cnt(s_ec), .cycles(s_cy), .fail_adr(s_fa), .fail_data(s_fd));
    mem_write_checker #(.WIDTH(8), .DEPTH(4), .TIMEOUT(TMO), .CNTW(16), .STOP_ON_ERR(1'b0)) dut_c (
        .clk(clk), .reset(reset), .bus(bus), .done(c_done), .pass(c_pass), .fail(c_fail), .timeout(c_to),
        .match_cnt(c_mc), .err_cnt(c_ec), .cycles(c_cy), .fail_adr(c_fa), .fail_data(c_fd));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outcome of one run: walk the writes in order against the table; the run ends at the
    // first stopping mismatch, at the len-th write, or at RUN cycle TMO-1 (timeout).
    function automatic res_t model(bit stop, int len);
        res_t r = '{default: 0};
        int t = TMO - 1;
        bit bad;
        if (len == 0) begin
            r.p = 1'b1;
            return r;
        end
        foreach (wq[i]) begin
            if (wq[i].k > t) break;
            bad = wq[i].a != tab_a[r.mc] || wq[i].d != tab_d[r.mc];
            r.mc++;
            if (bad) begin
                if (r.ec == 0) begin
                    r.fa = wq[i].a;
                    r.fd = wq[i].d;
                end
                r.ec++;
            end
            if ((stop && bad) || r.mc == len) begin
                r.f = r.ec != 0;
                r.p = !r.f;
                r.cy = (wq[i].k + 1 < t) ? wq[i].k + 1 : t;
                return r;
            end
        end
        r.f = 1'b1;
        r.to = 1'b1;
        r.cy = t;
        return r;
    endfunction

    task automatic check_res(string tag, res_t r, logic dn, logic ps, logic fl, logic to,
                             logic [2:0] mc, logic [15:0] ec, logic [15:0] cy, logic [7:0] fa, logic [7:0] fd);
        chk({tag, ".done"}, 32'(dn), 32'(r.p | r.f));
        chk({tag, ".pass"}, 32'(ps), 32'(r.p));
        chk({tag, ".fail"}, 32'(fl), 32'(r.f));
        chk({tag, ".timeout"}, 32'(to), 32'(r.to));
        chk({tag, ".match_cnt"}, 32'(mc), 32'(r.mc));
        chk({tag, ".err_cnt"}, 32'(ec), 32'(r.ec));
        chk({tag, ".cycles"}, 32'(cy), 32'(r.cy));
        chk({tag, ".fail_adr"}, 32'(fa), 32'(r.fa));
        chk({tag, ".fail_data"}, 32'(fd), 32'(r.fd));
    endtask

    task automatic check_both(string tag, int el);
        int len = (el > 4) ? 4 : el;
        check_res({tag, ".s"}, model(1'b1, len), s_done, s_pass, s_fail, s_to, s_mc, s_ec, s_cy, s_fa, s_fd);
        check_res({tag, ".c"}, model(1'b0, len), c_done, c_pass, c_fail, c_to, c_mc, c_ec, c_cy, c_fa, c_fd);
    endtask

    task automatic load(int i, logic [7:0] a, logic [7:0] d);
        bus.exp_we = 1'b1;
        bus.exp_idx = 2'(i);
        bus.exp_adr = a;
        bus.exp_data = d;
        tab_a[i] = a;
        tab_d[i] = d;
        tick;
        bus.exp_we = 1'b0;
    endtask

    task automatic start_run(int el);
        bus.exp_len = 3'(el);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        kk = 0;
        wp = 0;
    endtask

    task automatic drive(int n);
        for (int j = 0; j < n; j++) begin
            bus.memwrite = 1'b0;
            if (wp < wq.size() && wq[wp].k == kk) begin
                bus.memwrite = 1'b1;
                bus.adr = wq[wp].a;
                bus.writedata = wq[wp].d;
                wp++;
            end
            tick;
            kk++;
        end
        bus.memwrite = 1'b0;
    endtask

    task automatic run(string tag, int el);
        start_run(el);
        drive(60);
        tick;
        check_both(tag, el);
    endtask

    initial begin
        {bus.memwrite, bus.adr, bus.writedata, bus.exp_we, bus.exp_idx} = '0;
        {bus.exp_adr, bus.exp_data, bus.exp_len, bus.start} = '0;
        for (int i = 0; i < 4; i++) begin
            tab_a[i] = '0;
            tab_d[i] = '0;
        end
        tick;
        tick;
        chk("reset.s", {s_done, s_pass, s_fail, s_to, s_mc, s_ec[7:0], s_cy[7:0], s_fa, s_fd[0]}, 32'd0);
        chk("reset.c", {c_done, c_pass, c_fail, c_to, c_mc, c_ec[7:0], c_cy[7:0], c_fa, c_fd[0]}, 32'd0);
        reset = 1'b0;
        tick;

        // single expected write, matched 10 cycles after start; a RUN-time load must be ignored
        load(0, 8'hFF, 8'h0D);
        wq = '{'{10, 8'hFF, 8'h0D}};
        start_run(1);
        drive(5);
        {bus.exp_we, bus.exp_adr, bus.exp_data, bus.exp_idx} = {1'b1, 18'd0};
        drive(1);
        bus.exp_we = 1'b0;
        drive(4);
        chk("t1.early_done", 32'(s_done), 32'd0);
        drive(1);
        chk("t1.pass_latency", 32'(s_pass), 32'd1);
        chk("t1.match_latency", 32'(s_mc), 32'd1);
        drive(50);
        check_both("t1", 1);

        wq = '{'{3, 8'hFF, 8'h0C}};
        run("t2", 1);
        chk("t2.fail_data", 32'(s_fd), 32'h0C);

        // check-all mode only fails once the last entry is written
        load(0, 8'h10, 8'h01);
        load(1, 8'h11, 8'h01);
        load(2, 8'h12, 8'h02);
        load(3, 8'h13, 8'h03);
        wq = '{'{0, 8'h10, 8'h01}, '{1, 8'h11, 8'h05}, '{2, 8'h12, 8'h02}, '{3, 8'h13, 8'h03}};
        start_run(4);
        drive(3);
        chk("t3.c_not_done", 32'(c_done), 32'd0);
        chk("t3.s_failed", 32'(s_fail), 32'd1);
        drive(1);
        chk("t3.c_fail", 32'(c_fail), 32'd1);
        chk("t3.c_fail_adr", 32'(c_fa), 32'h11);
        drive(56);
        check_both("t3", 4);

        load(0, 8'h21, 8'h42);
        wq.delete();
        start_run(1);
        drive(49);
        chk("t4.before_timeout", 32'(s_done), 32'd0);
        drive(1);
        chk("t4.timeout", 32'(s_to), 32'd1);
        chk("t4.cycles", 32'(s_cy), 32'd49);
        drive(5);
        check_both("t4", 1);
        wq = '{'{49, 8'h21, 8'h42}};
        run("t4b", 1);

        wq = '{'{0, 8'h55, 8'h66}};
        start_run(0);
        chk("t5.zero_len_pass", 32'(s_pass), 32'd1);
        drive(3);
        check_both("t5", 0);
        load(1, 8'h31, 8'h32);
        load(2, 8'h41, 8'h42);
        load(3, 8'h51, 8'h52);
        wq = '{'{0, 8'h21, 8'h42}, '{1, 8'h31, 8'h32}, '{2, 8'h41, 8'h42}, '{3, 8'h51, 8'h52}};
        run("t5clamp", 7);

        // asynchronous reset mid-run clears outputs and the table
        start_run(4);
        drive(2);
        reset = 1'b1;
        #2;
        chk("t6.reset_s", {s_done, s_pass, s_fail, s_to, s_mc, s_ec[7:0], s_cy[7:0], s_fa, s_fd[0]}, 32'd0);
        chk("t6.reset_c", {c_done, c_pass, c_fail, c_to, c_mc, c_ec[7:0], c_cy[7:0], c_fa, c_fd[0]}, 32'd0);
        tick;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tab_a[i] = '0;
            tab_d[i] = '0;
        end
        wq = '{'{2, 8'h00, 8'h00}};
        run("t6.cleared", 1);
        load(0, 8'hA0, 8'hB0);
        load(1, 8'hA1, 8'hB1);
        wq = '{'{1, 8'hA0, 8'hB0}, '{4, 8'hA1, 8'hB1}};
        run("t6.reload", 2);

        for (int n = 0; n < 40; n++) begin
            int k;
            logic [7:0] a, d;
            for (int i = 0; i < 4; i++) load(i, 8'($urandom), 8'($urandom));
            wq.delete();
            k = $urandom_range(0, 3);
            for (int i = 0; i < 6; i++) begin
                a = (i < 4) ? tab_a[i] : 8'($urandom);
                d = (i < 4) ? tab_d[i] : 8'($urandom);
                if ($urandom_range(0, 4) == 0) d = d ^ (8'h01 << $urandom_range(0, 7));
                if ($urandom_range(0, 9) == 0) a = a ^ 8'h80;
                wq.push_back('{k, a, d});
                k += $urandom_range(1, 14);
            end
            run($sformatf("rnd%0d", n), $urandom_range(0, 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
